// File: rtl/iter_mdu.sv
// ---------------------------------------------------------------------------
// iter_mdu -- iterative multiply / divide / popcount-of-AND unit for EX stage
//
// Sits beside the combinational ALU. The pipeline raises start with op/a/b,
// stalls while busy is high, and sees a single-cycle done pulse when the
// results land in the HI/LO registers.
//
//   clk      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   start    in   request; accepted only in IDLE or DONE with flush low
//   flush    in   abort in-flight operation (wins over start)
//   op       in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 POPAND, 5 MTHI, 6 MTLO
//   a, b     in   operands (dividend / divisor for DIV, DIVU)
//   busy     out  operation iterating
//   done     out  one-cycle pulse on the cycle after results commit
//   hi, lo   out  HI / LO registers
// ---------------------------------------------------------------------------
module iter_mdu #(
    parameter int WIDTH    = 32,
    parameter int POP_STEP = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT   = 3'd0;
    localparam logic [2:0] OP_MULTU  = 3'd1;
    localparam logic [2:0] OP_DIV    = 3'd2;
    localparam logic [2:0] OP_DIVU   = 3'd3;
    localparam logic [2:0] OP_POPAND = 3'd4;
    localparam logic [2:0] OP_MTHI   = 3'd5;
    localparam logic [2:0] OP_MTLO   = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt;         // iterations remaining after this one
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;           // raw A: MTHI/MTLO source and div-by-zero HI
    logic                 r_a_neg, r_b_neg, r_b_zero;
    logic [2*WIDTH-1:0]   r_acc;         // product, or {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   r_x;           // shifting multiplicand, or divisor in low half
    logic [WIDTH-1:0]     r_y;           // multiplier bits, or a&b, consumed LSB first
    logic [WIDTH-1:0]     r_hi, r_lo;

    logic                 w_accept, w_commit, w_signed, w_is_div, w_is_mul;
    logic [WIDTH-1:0]     w_a_mag, w_b_mag, w_pop, w_diff, w_quo, w_rem;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]     w_hi_commit, w_lo_commit;
    logic [CW-1:0]        w_n_m1;

    assign w_accept = start && !flush && (r_state == S_IDLE || r_state == S_DONE);
    assign w_commit = (r_state == S_RUN) && !flush && (r_cnt == '0);

    // Operand conditioning at accept: signed ops iterate on magnitudes.
    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign w_a_mag  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_signed && b[WIDTH-1]) ? -b : b;
    assign w_is_mul = (r_op == OP_MULT) || (r_op == OP_MULTU);

    always_comb begin
        unique case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_n_m1 = CW'(WIDTH - 1);
            OP_POPAND:                          w_n_m1 = CW'(WIDTH / POP_STEP - 1);
            default:                            w_n_m1 = '0;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (flush)              w_state_nxt = S_IDLE;
                else if (r_cnt == '0)   w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = w_accept ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- one iteration of the datapath ----------------
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < POP_STEP; i++) w_pop = w_pop + WIDTH'(r_y[i]);
        // Restoring division: shift next dividend bit into the partial remainder.
        w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
        // The true difference is below the divisor, so the low WIDTH bits suffice.
        w_diff     = w_trial[WIDTH-1:0] - r_x[WIDTH-1:0];
        w_acc_step = r_acc;
        case (r_op)
            OP_MULT, OP_MULTU: w_acc_step = r_acc + (r_y[0] ? r_x : '0);
            OP_DIV, OP_DIVU: begin
                if (w_trial >= {1'b0, r_x[WIDTH-1:0]})
                    w_acc_step = {w_diff, r_acc[WIDTH-2:0], 1'b1};
                else
                    w_acc_step = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end
            OP_POPAND: w_acc_step = r_acc + {{WIDTH{1'b0}}, w_pop};
            default:   w_acc_step = r_acc;
        endcase
    end

    // ---------------- result formatting at the final iteration ----------------
    assign w_quo = w_acc_step[WIDTH-1:0];
    assign w_rem = w_acc_step[2*WIDTH-1:WIDTH];

    always_comb begin
        w_hi_commit = r_hi;
        w_lo_commit = r_lo;
        case (r_op)
            OP_MULT, OP_MULTU:
                {w_hi_commit, w_lo_commit} = (r_a_neg ^ r_b_neg) ? -w_acc_step : w_acc_step;
            OP_DIV, OP_DIVU: begin
                if (r_b_zero) begin
                    w_hi_commit = r_a;
                    w_lo_commit = '1;
                end else begin
                    // Truncating quotient; remainder follows the dividend's sign.
                    w_lo_commit = (r_a_neg ^ r_b_neg) ? -w_quo : w_quo;
                    w_hi_commit = r_a_neg ? -w_rem : w_rem;
                end
            end
            OP_POPAND: begin
                w_hi_commit = '0;
                w_lo_commit = w_quo;
            end
            OP_MTHI: w_hi_commit = r_a;
            OP_MTLO: w_lo_commit = r_a;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept)
                r_cnt <= w_n_m1;
            else if (r_state == S_RUN && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (w_commit) begin
                r_hi <= w_hi_commit;
                r_lo <= w_lo_commit;
            end
        end
    end

    // NOTE: the working registers are deliberately not reset; every operation
    // loads them at accept and nothing reads them outside RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op     <= op;
            r_a      <= a;
            r_a_neg  <= w_signed && a[WIDTH-1];
            r_b_neg  <= w_signed && b[WIDTH-1];
            r_b_zero <= (b == '0);
            r_acc    <= w_is_div ? {{WIDTH{1'b0}}, w_a_mag} : '0;
            r_x      <= {{WIDTH{1'b0}}, (w_is_div ? w_b_mag : w_a_mag)};
            r_y      <= (op == OP_POPAND) ? (a & b) : w_b_mag;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_step;
            if (w_is_mul) begin
                r_x <= r_x << 1;
                r_y <= r_y >> 1;
            end else begin
                r_y <= r_y >> POP_STEP;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_iter_mdu.sv
// ---------------------------------------------------------------------------
// tb_iter_mdu -- directed bench for iter_mdu (WIDTH=32, POP_STEP=4).
// Expected {hi,lo} and latency are queued when an operation is launched and
// popped when done is observed.
// ---------------------------------------------------------------------------
module tb_iter_mdu;
    logic        clk = 1'b0;
    logic        reset_n, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    iter_mdu #(.WIDTH(32), .POP_STEP(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] res;
        logic [31:0] lat;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;   // reference HI/LO

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] latency(input logic [2:0] o);
        if (o <= 3'd3)      return 32;
        else if (o == 3'd4) return 8;
        else                return 1;
    endfunction

    // Reference model of one operation given the current HI/LO.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        logic signed [63:0] sx, sy, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            3'd0: return sx * sy;
            3'd1: return {32'b0, x} * {32'b0, y};
            3'd2: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            3'd4: return {32'b0, 32'($countones(x & y))};
            3'd5: return {x, l};
            3'd6: return {h, x};
            default: return {h, l};
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] res, input bit expect_done);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (expect_done) begin
            sb_q.push_back('{res: res, lat: latency(o)});
            m_hi = res[63:32];
            m_lo = res[31:0];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles (pre already elapsed) until done, then scores it.
    task automatic wait_done(input string tag, input int pre);
        int   cnt;
        exp_t e;
        cnt = pre;
        while (busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_latency"}, 64'(cnt), 64'(e.lat));
            check({tag, "_done"}, 64'(done), 64'd1);
            check({tag, "_hilo"}, {hi, lo}, e.res);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_done_drop"}, {62'b0, busy, done}, 64'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] res);
        launch(o, x, y, res, 1'b1);
        wait_done(tag, 0);
        idle_check(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit          saw_done;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Default latency and signed multiply.
        run("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);

        // Divides.
        run("divu_100_7",   3'd3, 32'd100,       32'd7,         {32'd2, 32'd14});
        run("div_m7_2",     3'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run("div_mneg_m1",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        run("divu_by_zero", 3'd3, 32'h1234,      32'd0,         {32'h1234, 32'hFFFF_FFFF});

        // Moves and reserved op.
        run("mthi",     3'd5, 32'hCAFE_BABE, 32'd0, {32'hCAFE_BABE, 32'hFFFF_FFFF});
        run("mtlo",     3'd6, 32'h0000_0055, 32'd0, {32'hCAFE_BABE, 32'h0000_0055});
        run("reserved", 3'd7, 32'h1111_1111, 32'd9, {32'hCAFE_BABE, 32'h0000_0055});

        // Popcount of a&b.
        run("popand", 3'd4, 32'hF0F0_00FF, 32'hFF00_0F0F, {32'd0, 32'd8});

        // A few random operations scored against the reference model.
        for (int i = 0; i < 6; i++) begin
            ro = 3'($urandom_range(0, 4));
            rx = $urandom();
            ry = (i == 5) ? 32'd0 : $urandom();
            run("random_op", ro, rx, ry, model(ro, rx, ry, m_hi, m_lo));
        end

        // Flush at the 10th busy cycle of a divide.
        run("multu_5x6", 3'd1, 32'd5, 32'd6, {32'd0, 32'd30});
        launch(3'd3, 32'd9, 32'd2, '0, 1'b0);
        check("flush_busy_before", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", {62'b0, busy, done}, 64'd0);
        check("flush_hilo", {hi, lo}, {32'd0, 32'd30});
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("flush_no_done", 64'(saw_done), 64'd0);

        // Flush together with start is not accepted.
        start = 1'b1; flush = 1'b1; op = 3'd1; a = 32'd7; b = 32'd7;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_idle", {62'b0, busy, done}, 64'd0);
        @(negedge clk);
        check("flush_start_hilo", {hi, lo}, {32'd0, 32'd30});

        // Flush in DONE: done drops, results stay.
        launch(3'd1, 32'd2, 32'd3, {32'd0, 32'd6}, 1'b1);
        wait_done("flush_in_done", 0);
        start = 1'b1; flush = 1'b1; op = 3'd3; a = 32'd1; b = 32'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_done_state", {62'b0, busy, done}, 64'd0);
        check("flush_done_hilo", {hi, lo}, {32'd0, 32'd6});

        // Reset mid-RUN aborts and clears HI/LO.
        launch(3'd3, 32'd9, 32'd2, '0, 1'b0);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        check("reset_abort_state", {62'b0, busy, done}, 64'd0);
        check("reset_abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);

        // Back-to-back: start accepted in the DONE cycle.
        launch(3'd1, 32'd3, 32'd4, {32'd0, 32'd12}, 1'b1);
        wait_done("b2b_first", 0);
        launch(3'd3, 32'd12, 32'd5, {32'd2, 32'd2}, 1'b1);
        check("b2b_handover", {62'b0, busy, done}, 64'd2);
        wait_done("b2b_second", 0);
        idle_check("b2b_second");

        // Start pulses and operand changes during RUN are ignored.
        rx = 32'hFFFF_0000;
        ry = 32'h0001_2345;
        launch(3'd0, rx, ry, model(3'd0, rx, ry, m_hi, m_lo), 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd99; b = 32'd3;
        @(negedge clk);
        start = 1'b0; a = $urandom(); b = $urandom();
        repeat (3) @(negedge clk);
        start = 1'b1; op = 3'd5;
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0;
        wait_done("run_ignore", 9);
        idle_check("run_ignore");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
